// File: rtl/msg_receive_parser.sv
// msg_receive_parser
//   Pops 128-bit frame words from the downstream link FIFO, validates the
//   frame header word (header, type, destination, channel, length), unpacks
//   the payload MSB byte first and writes each byte into the per-channel
//   byte FIFO selected by the frame's data_channel field. The payload byte
//   sum is compared against the frame checksum at the end of the frame.
//
// Ports
//   sys_clk_i / rst_n_i      : clock, asynchronous active-low reset
//   MSG_ID                   : own node ID, frames for other IDs are dropped
//   ds_rd_clk_o, ds_rd_en_o  : downstream FIFO read clock and read strobe
//   ds_din_i, ds_empty_i     : downstream FIFO data (1 cycle after strobe), empty
//   wr_clk_o, wr_en_o        : per-channel byte FIFO clocks, one-hot write strobe
//   wr_dout_o                : byte bus, the same byte replicated per channel
//   prog_full_i              : per-channel backpressure
//   frame_done_pluse_o       : 1-cycle pulse, frame accepted
//   frame_err_pluse_o        : 1-cycle pulse, frame rejected or checksum bad
//   err_code_o               : cause of the last error (1..5), sticky
//   rx_frame_cnt_o           : frame_cnt of the last accepted frame
//   last_src_id_o            : src_id of the last accepted frame
//
// Downstream read handshake: ds_rd_en_o is raised only while the FIFO is
// not empty and the FSM wants a word; the word is consumed on the following
// cycle (rd_pend = 1) and no new strobe is issued while one is pending.
module msg_receive_parser #(
    parameter int          SENSOR_CHANNEL = 25,
    parameter logic [15:0] MAX_LEN        = 16'd4096
) (
    input  logic                          sys_clk_i,
    input  logic                          rst_n_i,
    input  logic [7:0]                    MSG_ID,
    output logic                          ds_rd_clk_o,
    output logic                          ds_rd_en_o,
    input  logic [127:0]                  ds_din_i,
    input  logic                          ds_empty_i,
    output logic [SENSOR_CHANNEL-1:0]     wr_clk_o,
    output logic [SENSOR_CHANNEL-1:0]     wr_en_o,
    output logic [SENSOR_CHANNEL*8-1:0]   wr_dout_o,
    input  logic [SENSOR_CHANNEL-1:0]     prog_full_i,
    output logic                          frame_done_pluse_o,
    output logic                          frame_err_pluse_o,
    output logic [2:0]                    err_code_o,
    output logic [15:0]                   rx_frame_cnt_o,
    output logic [7:0]                    last_src_id_o
);

    localparam logic [31:0] HEADER   = 32'hFDF7_EB90;
    localparam logic [8:0]  CH_LIMIT = 9'(SENSOR_CHANNEL);

    typedef enum logic [2:0] {
        S_HUNT, S_CHECK, S_PAYLOAD, S_UNPACK, S_DROP, S_END
    } state_t;

    state_t state, state_nxt;

    logic         rd_pend;
    logic [3:0]   ftype_q;
    logic [15:0]  fcnt_q;
    logic [7:0]   src_q, des_q, ch_q, csum_q;
    logic [15:0]  len_q;
    logic [127:0] word_q;
    logic [15:0]  remaining_q;
    logic [3:0]   byte_idx_q;
    logic [16:0]  words_left_q;
    logic [7:0]   sum_q;
    logic [SENSOR_CHANNEL-1:0] wr_en_q;
    logic [7:0]   wr_byte_q;
    logic [2:0]   err_code_q;
    logic [15:0]  rx_cnt_q;
    logic [7:0]   src_out_q;

    logic [SENSOR_CHANNEL-1:0] ch_onehot;
    logic         ch_full, emit, hdr_hit, need_word, sum_ok;
    logic [2:0]   chk_err;
    logic [127:0] word_shifted;
    logic [7:0]   cur_byte;
    logic [16:0]  word_cnt;
    logic         unused_bits;

    // data_type and the zero tail are carried in the frame but not needed here
    assign unused_bits = ^{ds_din_i[59:52], ds_din_i[19:0]};

    always_comb begin
        ch_onehot = '0;
        for (int i = 0; i < SENSOR_CHANNEL; i++) begin
            ch_onehot[i] = (ch_q == 8'(i));
        end
    end

    assign ch_full      = |(prog_full_i & ch_onehot);
    assign emit         = (state == S_UNPACK) && !ch_full;
    assign hdr_hit      = rd_pend && (ds_din_i[127:96] == HEADER);
    // MSB byte first: shift the current byte up to the top of the word
    assign word_shifted = word_q << {byte_idx_q, 3'b000};
    assign cur_byte     = word_shifted[127:120];
    // 17-bit so that len = 16'hFFFF does not wrap
    assign word_cnt     = (17'(len_q) + 17'd15) >> 4;
    assign sum_ok       = (sum_q == csum_q);

    // Header checks in priority order; 0 means the frame is good
    always_comb begin
        chk_err = 3'd0;
        if (ftype_q != 4'd1)               chk_err = 3'd1;
        else if (len_q > MAX_LEN)          chk_err = 3'd2;
        else if (des_q != MSG_ID)          chk_err = 3'd3;
        else if ({1'b0, ch_q} >= CH_LIMIT) chk_err = 3'd4;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_HUNT;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_HUNT:    if (hdr_hit) state_nxt = S_CHECK;
            S_CHECK: begin
                if (chk_err == 3'd2)      state_nxt = S_HUNT;  // length untrusted
                else if (chk_err != 3'd0) state_nxt = S_DROP;
                else if (len_q == 16'd0)  state_nxt = S_END;
                else                      state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: if (rd_pend) state_nxt = S_UNPACK;
            S_UNPACK: begin
                if (emit) begin
                    if (remaining_q == 16'd1)   state_nxt = S_END;
                    else if (byte_idx_q == 4'd15) state_nxt = S_PAYLOAD;
                end
            end
            S_DROP:    if (words_left_q == 17'd0 && !rd_pend) state_nxt = S_HUNT;
            S_END:     state_nxt = S_HUNT;
            default:   state_nxt = S_HUNT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        need_word = (state == S_HUNT) || (state == S_PAYLOAD) ||
                    ((state == S_DROP) && (words_left_q != 17'd0));
        ds_rd_en_o         = rst_n_i && need_word && !rd_pend && !ds_empty_i;
        frame_done_pluse_o = (state == S_END) && sum_ok;
        frame_err_pluse_o  = ((state == S_CHECK) && (chk_err != 3'd0)) ||
                             ((state == S_END) && !sum_ok);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_pend      <= 1'b0;
            ftype_q      <= '0;
            fcnt_q       <= '0;
            src_q        <= '0;
            des_q        <= '0;
            ch_q         <= '0;
            len_q        <= '0;
            csum_q       <= '0;
            word_q       <= '0;
            remaining_q  <= '0;
            byte_idx_q   <= '0;
            words_left_q <= '0;
            sum_q        <= '0;
            wr_en_q      <= '0;
            wr_byte_q    <= '0;
            err_code_q   <= '0;
            rx_cnt_q     <= '0;
            src_out_q    <= '0;
        end else begin
            rd_pend <= ds_rd_en_o;
            wr_en_q <= emit ? ch_onehot : '0;

            if (state == S_HUNT && hdr_hit) begin
                ftype_q <= ds_din_i[95:92];
                fcnt_q  <= ds_din_i[91:76];
                src_q   <= ds_din_i[75:68];
                des_q   <= ds_din_i[67:60];
                ch_q    <= ds_din_i[51:44];
                len_q   <= ds_din_i[43:28];
                csum_q  <= ds_din_i[27:20];
            end

            if (state == S_CHECK) begin
                remaining_q  <= len_q;
                words_left_q <= word_cnt;
                sum_q        <= '0;
                byte_idx_q   <= '0;
                if (chk_err != 3'd0) err_code_q <= chk_err;
            end

            if (state == S_PAYLOAD && rd_pend) begin
                word_q     <= ds_din_i;
                byte_idx_q <= '0;
            end

            if (emit) begin
                wr_byte_q   <= cur_byte;
                sum_q       <= sum_q + cur_byte;
                remaining_q <= remaining_q - 16'd1;
                byte_idx_q  <= byte_idx_q + 4'd1;
            end

            if (state == S_DROP && rd_pend) words_left_q <= words_left_q - 17'd1;

            if (state == S_END) begin
                if (sum_ok) begin
                    rx_cnt_q  <= fcnt_q;
                    src_out_q <= src_q;
                end else begin
                    err_code_q <= 3'd5;
                end
            end
        end
    end

    assign ds_rd_clk_o    = sys_clk_i;
    assign wr_clk_o       = {SENSOR_CHANNEL{sys_clk_i}};
    assign wr_en_o        = wr_en_q;
    assign wr_dout_o      = {SENSOR_CHANNEL{wr_byte_q}};
    assign err_code_o     = err_code_q;
    assign rx_frame_cnt_o = rx_cnt_q;
    assign last_src_id_o  = src_out_q;

endmodule

// File: tb/tb_msg_receive_parser.sv
module tb_msg_receive_parser;
  localparam int SC = 25;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]      msg_id = 8'h05;
  logic            ds_rd_clk, ds_rd_en;
  logic [127:0]    ds_din = '0;
  logic            ds_empty = 1'b1;
  logic [SC-1:0]   wr_clk, wr_en;
  logic [SC*8-1:0] wr_dout;
  logic [SC-1:0]   prog_full = '0;
  logic            done_p, err_p;
  logic [2:0]      err_code;
  logic [15:0]     rx_cnt;
  logic [7:0]      last_src;

  msg_receive_parser #(.SENSOR_CHANNEL(SC), .MAX_LEN(16'd4096)) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .MSG_ID(msg_id),
    .ds_rd_clk_o(ds_rd_clk), .ds_rd_en_o(ds_rd_en), .ds_din_i(ds_din),
    .ds_empty_i(ds_empty), .wr_clk_o(wr_clk), .wr_en_o(wr_en),
    .wr_dout_o(wr_dout), .prog_full_i(prog_full),
    .frame_done_pluse_o(done_p), .frame_err_pluse_o(err_p),
    .err_code_o(err_code), .rx_frame_cnt_o(rx_cnt), .last_src_id_o(last_src)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, wr_cnt = 0;
  int base_done, base_err, base_wr;
  bit bp_rand = 0;
  logic [15:0]  exp_rx = '0;
  logic [7:0]   exp_src = '0;
  logic [15:0]  exp_q[$];   // {channel, byte} in write order
  logic [127:0] fifo_q[$];  // downstream FIFO contents
  logic [7:0]   pay[$];     // payload of the frame being built

  // ---------------- downstream FIFO model ----------------
  always @(posedge clk) begin
    if (ds_rd_en) begin
      if (fifo_q.size() > 0) ds_din <= fifo_q.pop_front();
      else begin
        checks++; errors++;
        $display("FAIL fifo_underflow: read strobe with empty FIFO");
      end
    end
  end
  always @(negedge clk) ds_empty <= (fifo_q.size() == 0);

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_p) done_cnt++;
      if (err_p) err_cnt++;
      if (wr_en !== '0) begin
        int ch;
        bit slices_ok;
        logic [15:0] got, e;
        ch = 0;
        slices_ok = 1;
        for (int i = 0; i < SC; i++) if (wr_en[i]) ch = i;
        for (int i = 0; i < SC; i++) if (wr_dout[i*8 +: 8] !== wr_dout[7:0]) slices_ok = 0;
        wr_cnt++;
        checks++;
        if (!$onehot(wr_en) || !slices_ok) begin
          errors++;
          $display("FAIL wr_bus_shape: wr_en=%h onehot/slices bad", wr_en);
        end
        got = {8'(ch), wr_dout[7:0]};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got ch %0d byte %h, none expected", ch, wr_dout[7:0]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL write_data: got ch %0d byte %h, want ch %0d byte %h",
                     got[15:8], got[7:0], e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic make_payload(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 127)));
  endtask

  function automatic logic [7:0] pay_sum();
    logic [7:0] s;
    s = 8'h00;
    foreach (pay[i]) s = s + pay[i];
    return s;
  endfunction

  task automatic push_frame(input logic [3:0] ft, input logic [15:0] cnt, input logic [7:0] src,
                            input logic [7:0] des, input logic [7:0] ch, input logic [15:0] len,
                            input logic [7:0] csum, input int nwords);
    logic [127:0] w;
    logic [7:0] dt;
    dt = 8'($urandom);
    w = {32'hFDF7EB90, ft, cnt, src, des, dt, ch, len, csum, 20'h0};
    fifo_q.push_back(w);
    for (int k = 0; k < nwords; k++) begin
      w = '0;
      for (int b = 0; b < 16; b++) begin
        int idx;
        idx = k * 16 + b;
        w[127-8*b -: 8] = (idx < pay.size()) ? pay[idx] : 8'($urandom_range(0, 127));
      end
      fifo_q.push_back(w);
    end
  endtask

  task automatic expect_pay(input logic [7:0] ch);
    foreach (pay[i]) exp_q.push_back({ch, pay[i]});
  endtask

  task automatic snap();
    base_done = done_cnt;
    base_err  = err_cnt;
    base_wr   = wr_cnt;
  endtask

  // Bounded wait for frame events; a timeout shows up in the caller's event checks
  task automatic wait_events(input int nd, input int ne, input int budget);
    int n;
    n = 0;
    while (((done_cnt - base_done) < nd || (err_cnt - base_err) < ne) && n < budget) begin
      @(negedge clk); #1;
      if (bp_rand) prog_full = SC'($urandom);
      n++;
    end
    prog_full = '0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_en !== '0 || ds_rd_en !== 1'b0 || done_p !== 1'b0 || err_p !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: wr_en=%h rd_en=%b done=%b err=%b, want all 0", wr_en, ds_rd_en, done_p, err_p);
    end
    checks++;
    if (err_code !== 3'd0 || rx_cnt !== 16'd0 || last_src !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs: err_code=%0d rx=%h src=%h, want 0", err_code, rx_cnt, last_src);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ds_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_read: rd_en=%b with empty FIFO, want 0", ds_rd_en);
    end
  endtask

  task automatic test_basic();
    pay.delete();
    for (int i = 1; i <= 20; i++) pay.push_back(8'(i));
    snap();
    push_frame(4'd1, 16'h1234, 8'hA5, 8'h05, 8'd3, 16'd20, pay_sum(), 2);
    expect_pay(8'd3);
    exp_rx = 16'h1234; exp_src = 8'hA5;
    wait_events(1, 0, 2000);
    checks++;
    if (done_cnt - base_done !== 1 || err_cnt - base_err !== 0) begin
      errors++;
      $display("FAIL basic_events: done %0d err %0d, want 1 0", done_cnt - base_done, err_cnt - base_err);
    end
    checks++;
    if (wr_cnt - base_wr !== 20 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL basic_writes: %0d writes, %0d missing, want 20 0", wr_cnt - base_wr, exp_q.size());
    end
    checks++;
    if (rx_cnt !== exp_rx || last_src !== exp_src) begin
      errors++;
      $display("FAIL basic_ids: rx=%h src=%h, want %h %h", rx_cnt, last_src, exp_rx, exp_src);
    end
  endtask

  task automatic test_backpressure();
    int n, stalled;
    pay.delete();
    for (int i = 1; i <= 20; i++) pay.push_back(8'(i));
    snap();
    push_frame(4'd1, 16'h1235, 8'hA6, 8'h05, 8'd3, 16'd20, pay_sum(), 2);
    expect_pay(8'd3);
    exp_rx = 16'h1235; exp_src = 8'hA6;
    n = 0;
    while (wr_cnt - base_wr < 4 && n < 500) begin @(negedge clk); #1; n++; end
    prog_full[3] = 1'b1;
    stalled = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (wr_en !== '0) stalled++;
    end
    checks++;
    if (stalled !== 0 || wr_cnt - base_wr !== 4) begin
      errors++;
      $display("FAIL bp_hold: %0d writes during hold, total %0d, want 0 and 4", stalled, wr_cnt - base_wr);
    end
    prog_full = '0;
    wait_events(1, 0, 2000);
    checks++;
    if (done_cnt - base_done !== 1 || err_cnt - base_err !== 0) begin
      errors++;
      $display("FAIL bp_events: done %0d err %0d, want 1 0", done_cnt - base_done, err_cnt - base_err);
    end
    checks++;
    if (wr_cnt - base_wr !== 20 || exp_q.size() !== 0 || rx_cnt !== exp_rx) begin
      errors++;
      $display("FAIL bp_writes: %0d writes, %0d missing, rx=%h, want 20 0 %h", wr_cnt - base_wr, exp_q.size(), rx_cnt, exp_rx);
    end
  endtask

  task automatic test_garbage_len0();
    logic [127:0] g;
    snap();
    for (int i = 0; i < 2; i++) begin
      g = {$urandom, $urandom, $urandom, $urandom};
      g[127] = 1'b0;  // cannot match the header
      fifo_q.push_back(g);
    end
    pay.delete();
    push_frame(4'd1, 16'h0042, 8'h11, 8'h05, 8'd0, 16'd0, 8'h00, 0);
    exp_rx = 16'h0042; exp_src = 8'h11;
    wait_events(1, 0, 500);
    checks++;
    if (done_cnt - base_done !== 1 || err_cnt - base_err !== 0 || wr_cnt - base_wr !== 0) begin
      errors++;
      $display("FAIL len0_events: done %0d err %0d writes %0d, want 1 0 0",
               done_cnt - base_done, err_cnt - base_err, wr_cnt - base_wr);
    end
    checks++;
    if (rx_cnt !== exp_rx || last_src !== exp_src) begin
      errors++;
      $display("FAIL len0_ids: rx=%h src=%h, want %h %h", rx_cnt, last_src, exp_rx, exp_src);
    end
  endtask

  task automatic test_drop();
    make_payload(33);
    snap();
    push_frame(4'd1, 16'h0100, 8'h22, 8'h07, 8'd3, 16'd33, pay_sum(), 3);
    make_payload(10);
    push_frame(4'd1, 16'h0101, 8'h23, 8'h05, 8'd7, 16'd10, pay_sum(), 1);
    expect_pay(8'd7);
    exp_rx = 16'h0101; exp_src = 8'h23;
    wait_events(1, 1, 2000);
    checks++;
    if (done_cnt - base_done !== 1 || err_cnt - base_err !== 1 || err_code !== 3'd3) begin
      errors++;
      $display("FAIL drop_events: done %0d err %0d code %0d, want 1 1 3",
               done_cnt - base_done, err_cnt - base_err, err_code);
    end
    checks++;
    if (wr_cnt - base_wr !== 10 || exp_q.size() !== 0 || fifo_q.size() !== 0 || rx_cnt !== exp_rx) begin
      errors++;
      $display("FAIL drop_follow: writes %0d missing %0d fifo %0d rx=%h, want 10 0 0 %h",
               wr_cnt - base_wr, exp_q.size(), fifo_q.size(), rx_cnt, exp_rx);
    end
  endtask

  task automatic test_errors();
    int ft[3]      = '{2, 1, 1};
    int ln[3]      = '{17, 4097, 5};
    int chs[3]     = '{3, 3, 25};
    int nw[3]      = '{2, 0, 1};
    int ec[3]      = '{1, 2, 4};
    int good_ln[3] = '{5, 4096, 12};
    int good_ch[3] = '{24, 0, 24};
    for (int t = 0; t < 3; t++) begin
      make_payload(nw[t] * 16 < ln[t] ? nw[t] * 16 : ln[t]);
      snap();
      push_frame(4'(ft[t]), 16'(16'h0500 + t), 8'h30, 8'h05, 8'(chs[t]), 16'(ln[t]), pay_sum(), nw[t]);
      make_payload(good_ln[t]);
      push_frame(4'd1, 16'(16'h0600 + t), 8'(8'h40 + t), 8'h05, 8'(good_ch[t]), 16'(good_ln[t]),
                 pay_sum(), (good_ln[t] + 15) / 16);
      expect_pay(8'(good_ch[t]));
      exp_rx = 16'(16'h0600 + t); exp_src = 8'(8'h40 + t);
      wait_events(1, 1, 12000);
      checks++;
      if (done_cnt - base_done !== 1 || err_cnt - base_err !== 1 || err_code !== 3'(ec[t])) begin
        errors++;
        $display("FAIL err_case%0d: done %0d err %0d code %0d, want 1 1 %0d",
                 t, done_cnt - base_done, err_cnt - base_err, err_code, ec[t]);
      end
      checks++;
      if (wr_cnt - base_wr !== good_ln[t] || exp_q.size() !== 0 || rx_cnt !== exp_rx || last_src !== exp_src) begin
        errors++;
        $display("FAIL err_follow%0d: writes %0d missing %0d rx=%h src=%h, want %0d 0 %h %h",
                 t, wr_cnt - base_wr, exp_q.size(), rx_cnt, last_src, good_ln[t], exp_rx, exp_src);
      end
    end
  endtask

  task automatic test_bad_csum();
    make_payload(25);
    snap();
    push_frame(4'd1, 16'h0200, 8'h33, 8'h05, 8'd5, 16'd25, pay_sum() + 8'd1, 2);
    expect_pay(8'd5);
    wait_events(0, 1, 2000);
    checks++;
    if (done_cnt - base_done !== 0 || err_cnt - base_err !== 1 || err_code !== 3'd5) begin
      errors++;
      $display("FAIL csum_events: done %0d err %0d code %0d, want 0 1 5",
               done_cnt - base_done, err_cnt - base_err, err_code);
    end
    checks++;
    if (wr_cnt - base_wr !== 25 || exp_q.size() !== 0 || rx_cnt !== exp_rx || last_src !== exp_src) begin
      errors++;
      $display("FAIL csum_writes: writes %0d missing %0d rx=%h src=%h, want 25 0 %h %h",
               wr_cnt - base_wr, exp_q.size(), rx_cnt, last_src, exp_rx, exp_src);
    end
  endtask

  task automatic test_random();
    int len;
    logic [7:0] ch, src;
    logic [15:0] cnt;
    bp_rand = 1;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 48);
      ch  = 8'($urandom_range(0, SC - 1));
      cnt = 16'($urandom);
      src = 8'($urandom);
      make_payload(len);
      snap();
      push_frame(4'd1, cnt, src, 8'h05, ch, 16'(len), pay_sum(), (len + 15) / 16);
      expect_pay(ch);
      exp_rx = cnt; exp_src = src;
      wait_events(1, 0, 3000);
      checks++;
      if (done_cnt - base_done !== 1 || err_cnt - base_err !== 0 || wr_cnt - base_wr !== len || exp_q.size() !== 0) begin
        errors++;
        $display("FAIL rand%0d_stream: done %0d err %0d writes %0d missing %0d, want 1 0 %0d 0",
                 f, done_cnt - base_done, err_cnt - base_err, wr_cnt - base_wr, exp_q.size(), len);
      end
      checks++;
      if (rx_cnt !== exp_rx || last_src !== exp_src) begin
        errors++;
        $display("FAIL rand%0d_ids: rx=%h src=%h, want %h %h", f, rx_cnt, last_src, exp_rx, exp_src);
      end
    end
    bp_rand = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    make_payload(40);
    snap();
    push_frame(4'd1, 16'h0300, 8'h44, 8'h05, 8'd2, 16'd40, pay_sum(), 3);
    expect_pay(8'd2);
    n = 0;
    while (wr_cnt - base_wr < 6 && n < 500) begin @(negedge clk); #1; n++; end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== '0 || done_p !== 1'b0 || err_p !== 1'b0) begin
      errors++;
      $display("FAIL midreset_strobes: wr_en=%h done=%b err=%b, want 0", wr_en, done_p, err_p);
    end
    exp_q.delete();
    exp_rx = '0; exp_src = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_cnt !== exp_rx || last_src !== exp_src || err_code !== 3'd0) begin
      errors++;
      $display("FAIL midreset_regs: rx=%h src=%h code %0d, want 0", rx_cnt, last_src, err_code);
    end
    #2 rst_n = 1'b1;
    make_payload(9);
    snap();
    push_frame(4'd1, 16'h0301, 8'h45, 8'h05, 8'd9, 16'd9, pay_sum(), 1);
    expect_pay(8'd9);
    exp_rx = 16'h0301; exp_src = 8'h45;
    wait_events(1, 0, 2000);
    checks++;
    if (done_cnt - base_done !== 1 || err_cnt - base_err !== 0 || wr_cnt - base_wr !== 9 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL midreset_follow: done %0d err %0d writes %0d missing %0d, want 1 0 9 0",
               done_cnt - base_done, err_cnt - base_err, wr_cnt - base_wr, exp_q.size());
    end
    checks++;
    if (rx_cnt !== exp_rx || last_src !== exp_src || fifo_q.size() !== 0) begin
      errors++;
      $display("FAIL midreset_ids: rx=%h src=%h fifo %0d, want %h %h 0", rx_cnt, last_src, fifo_q.size(), exp_rx, exp_src);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_garbage_len0();
    test_drop();
    test_errors();
    test_bad_csum();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
